// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-port memory arbiter: fetch port, data port and the
// single external memory port.
interface mem_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] memaddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wdata_oe;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // Handshake: a requester holds req/addr/we/wdata stable until its one-cycle
    // ack; the memory holds nothing -- the arbiter keeps its strobes, address
    // and write data constant until it samples mem_ready=1.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_ack, i_rdata, d_ack, d_rdata,
        output mem_re, mem_we, memaddr, mem_wdata, mem_wdata_oe
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  mem_re, mem_we, memaddr, mem_wdata, mem_wdata_oe
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-access memory port between a
// read-only fetch port and a read/write data port.
module mem_arbiter #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic [1:0]    o_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t            r_state,      w_state_nx;
    logic              r_last_grant, w_last_grant_nx;
    logic              r_grant,      w_grant_nx;
    logic              r_re,         w_re_nx;
    logic              r_we,         w_we_nx;
    logic [ADDR_W-1:0] r_addr,       w_addr_nx;
    logic [DATA_W-1:0] r_wdata,      w_wdata_nx;
    logic              r_i_ack,      w_i_ack_nx;
    logic              r_d_ack,      w_d_ack_nx;
    logic [DATA_W-1:0] r_i_rdata,    w_i_rdata_nx;
    logic [DATA_W-1:0] r_d_rdata,    w_d_rdata_nx;
    logic              w_pick_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_D;
            r_grant      <= GRANT_I;
            r_re         <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_i_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_last_grant <= w_last_grant_nx;
            r_grant      <= w_grant_nx;
            r_re         <= w_re_nx;
            r_we         <= w_we_nx;
            r_addr       <= w_addr_nx;
            r_wdata      <= w_wdata_nx;
            r_i_ack      <= w_i_ack_nx;
            r_d_ack      <= w_d_ack_nx;
            r_i_rdata    <= w_i_rdata_nx;
            r_d_rdata    <= w_d_rdata_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_last_grant_nx = r_last_grant;
        w_grant_nx      = r_grant;
        w_re_nx         = r_re;
        w_we_nx         = r_we;
        w_addr_nx       = r_addr;
        w_wdata_nx      = r_wdata;
        w_i_ack_nx      = 1'b0;
        w_d_ack_nx      = 1'b0;
        w_i_rdata_nx    = r_i_rdata;
        w_d_rdata_nx    = r_d_rdata;
        w_pick_d        = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // Data wins only if alone or if fetch was served last.
                    w_pick_d        = bus.d_req && (!bus.i_req || (r_last_grant == GRANT_I));
                    w_state_nx      = BUSY;
                    w_grant_nx      = w_pick_d;
                    w_last_grant_nx = w_pick_d;
                    if (w_pick_d) begin
                        w_addr_nx  = bus.d_addr;
                        w_wdata_nx = bus.d_wdata;
                        w_re_nx    = ~bus.d_we;
                        w_we_nx    = bus.d_we;
                    end else begin
                        w_addr_nx  = bus.i_addr;
                        w_wdata_nx = '0;
                        w_re_nx    = 1'b1;
                        w_we_nx    = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    w_state_nx = RESP;
                    w_re_nx    = 1'b0;
                    w_we_nx    = 1'b0;
                    if (r_grant == GRANT_D) begin
                        w_d_ack_nx = 1'b1;
                        if (r_re) begin
                            w_d_rdata_nx = bus.mem_rdata;
                        end
                    end else begin
                        w_i_ack_nx   = 1'b1;
                        w_i_rdata_nx = bus.mem_rdata;
                    end
                end
            end
            RESP: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign bus.i_ack        = r_i_ack;
    assign bus.i_rdata      = r_i_rdata;
    assign bus.d_ack        = r_d_ack;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.mem_re       = r_re;
    assign bus.mem_we       = r_we;
    assign bus.mem_wdata_oe = r_we;
    assign bus.memaddr      = r_addr;
    assign bus.mem_wdata    = r_wdata;
    assign o_state          = r_state;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 30, word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width.
REQ-003 The block SHALL have port clk, input, 1, the only clock; all logic rising-edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port i_req, input, 1, fetch request (read only).
REQ-006 The block SHALL have port i_addr, input, ADDR_W, fetch word address.
REQ-007 The block SHALL have port i_ack, output, 1, one-cycle fetch completion pulse.
REQ-008 The block SHALL have port i_rdata, output, DATA_W, fetch read data, valid while i_ack=1.
REQ-009 The block SHALL have port d_req, input, 1, data request.
REQ-010 The block SHALL have port d_we, input, 1, data write (1) or read (0).
REQ-011 The block SHALL have ports d_addr (input, ADDR_W) and d_wdata (input, DATA_W), data address and write data.
REQ-012 The block SHALL have port d_ack, output, 1, one-cycle data completion pulse.
REQ-013 The block SHALL have port d_rdata, output, DATA_W, data read data, valid while d_ack=1.
REQ-014 The block SHALL have ports mem_re and mem_we, output, 1 each, memory read/write strobes.
REQ-015 The block SHALL have port memaddr, output, ADDR_W, memory word address.
REQ-016 The block SHALL have ports mem_wdata (output, DATA_W) and mem_wdata_oe (output, 1, equals mem_we); external tristate drives memdata.
REQ-017 The block SHALL have ports mem_rdata (input, DATA_W) and mem_ready (input, 1, access complete this cycle).

Function
REQ-018 States SHALL be IDLE, BUSY and RESP; one access in flight at most.
REQ-019 In IDLE with no request pending, the state SHALL remain IDLE and all strobes SHALL stay 0.
REQ-020 In IDLE with exactly one request pending, that port SHALL be granted, its addr/we/wdata registered, and the state SHALL move to BUSY; strobes are asserted from the next cycle (registered outputs).
REQ-021 In IDLE with both requests pending, the port not granted last SHALL win (round-robin); last_grant resets to data, so fetch wins the first tie.
REQ-022 A fetch grant SHALL drive mem_re=1, mem_we=0; a data grant SHALL drive mem_re=~d_we, mem_we=d_we.
REQ-023 In BUSY, memaddr, mem_wdata, mem_re and mem_we SHALL be held constant until a cycle with mem_ready=1.
REQ-024 On mem_ready=1 in BUSY, a read SHALL capture mem_rdata into the granted port's rdata, and on the next edge strobes SHALL drop to 0, the granted ack SHALL be 1, and the state SHALL move to RESP.
REQ-025 RESP SHALL last exactly one cycle with the ack high; no arbitration occurs in RESP; the next state is IDLE.
REQ-026 Requesters SHALL hold req/addr/wdata stable until ack; req sampled again in the IDLE after RESP is treated as a new request.
REQ-027 Zero-wait memory (mem_ready=1 in first BUSY cycle) SHALL give 3 cycles per access: grant, BUSY, RESP.
REQ-028 mem_ready in IDLE or RESP SHALL be ignored.
REQ-029 On a data write, d_rdata SHALL remain unchanged; i_ack and d_ack SHALL never be high together.
REQ-030 Request deassertion during BUSY SHALL NOT abort the access; the ack is still issued.

Reset
REQ-031 While rst=1 at an edge, the state SHALL go to IDLE, last_grant to data, and mem_re, mem_we, mem_wdata_oe, i_ack and d_ack SHALL be 0.
REQ-032 While rst=1 at an edge, memaddr, mem_wdata, i_rdata and d_rdata SHALL be 0.
REQ-033 Reset during BUSY or RESP SHALL abandon the access with no ack issued.

Verification
REQ-034 Fetch only: i_req=1, i_addr=0x10, mem_ready tied 1, mem_rdata=0xDEADBEEF -> mem_re=1 with memaddr=0x10 for one cycle, then i_ack=1 and i_rdata=0xDEADBEEF one cycle later, 3 cycles total.
REQ-035 Simultaneous requests after reset: both req=1, both held -> grants alternate fetch, data, fetch, data, and each ack pulses once per grant.
REQ-036 Write with wait states: d_we=1, d_addr=0x20, d_wdata=0x12345678, mem_ready low 3 cycles -> mem_we, mem_wdata_oe, addr and data held 4 cycles, then d_ack=1 and d_rdata unchanged.
REQ-037 Reset mid-access: assert rst during BUSY -> next edge all strobes 0, no ack; after release, a fetch wins the first tie.
REQ-038 Spurious ready: mem_ready=1 in IDLE with no request -> no strobes and no acks.
